imem_loader: RTL and testbench

- Write-side counterpart of instruction fetch. Fetch reads words from instruction memory at the PC; this block fills that memory before execution.
- Accepts a byte stream (e.g. from a UART receiver) through a valid/ready handshake.
- Assembles the bytes into 32-bit big-endian instruction words and drives the instruction-memory write port at word-aligned byte addresses.
- Holds the CPU while a load is in progress.

---
 rtl/imem_loader.sv | 144 ++++++++++++++
 tb/tb_imem_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: assembles a byte stream into big-endian words and writes instruction memory.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int DEPTH = 256,
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_num_words,
    input  logic             i_byte_valid,
    input  logic [7:0]       i_byte,
    output logic             o_byte_ready,
    output logic             o_imem_we,
    output logic [31:0]      o_imem_addr,
    output logic [31:0]      o_imem_wdata,
    output logic             o_busy,
    output logic             o_cpu_hold,
    output logic             o_done,
    output logic             o_error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK = 3'd4;
`endif

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [2:0]       state;
    logic [31:0]      asm_q;
    logic [1:0]       byte_cnt;
    logic [CNT_W-1:0] word_idx;
    logic [CNT_W-1:0] num_words_q;
    logic             done_q;
    logic             error_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       xor_q;
`endif

    always_comb begin
        o_byte_ready = (state == S_RECV);
        o_busy       = (state == S_RECV) || (state == S_WRITE);
`ifdef IMEM_LOADER_CHECKSUM_EN
        o_byte_ready = o_byte_ready || (state == S_CHECK);
        o_busy       = o_busy || (state == S_CHECK);
`endif
    end

    assign o_cpu_hold   = o_busy;
    assign o_imem_we    = (state == S_WRITE);
    assign o_imem_addr  = addr_q;
    assign o_imem_wdata = wdata_q;
    assign o_done       = done_q;
    assign o_error      = error_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            asm_q       <= '0;
            byte_cnt    <= '0;
            word_idx    <= '0;
            num_words_q <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q       <= '0;
`endif
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                        word_idx    <= '0;
                        byte_cnt    <= '0;
                        asm_q       <= '0;
                        num_words_q <= i_num_words;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_q       <= '0;
`endif
                        if (i_num_words == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else if (i_num_words > DEPTH_C) begin
                            state   <= S_DONE;
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                        end else begin
                            state <= S_RECV;
                        end
                    end
                end
                S_RECV: begin
                    if (i_byte_valid) begin
                        asm_q    <= {asm_q[23:0], i_byte};
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_q    <= xor_q ^ i_byte;
`endif
                        // Capture the word here so the write port holds it afterwards.
                        if (byte_cnt == 2'd3) begin
                            state   <= S_WRITE;
                            addr_q  <= {{(30-CNT_W){1'b0}}, word_idx, 2'b00};
                            wdata_q <= {asm_q[23:0], i_byte};
                        end
                    end
                end
                S_WRITE: begin
                    word_idx <= word_idx + ONE_C;
                    if (word_idx == num_words_q - ONE_C) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state  <= S_CHECK;
`else
                        state  <= S_DONE;
                        done_q <= 1'b1;
`endif
                    end else begin
                        state <= S_RECV;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (i_byte_valid) begin
                        error_q <= (i_byte != xor_q);
                        done_q  <= 1'b1;
                        state   <= S_DONE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader.
// Expected writes are queued as bytes are driven and checked on each write strobe.
module tb_imem_loader;

    localparam int DEPTH = 256;
    localparam int CNT_W = 9;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             i_start = 1'b0;
    logic [CNT_W-1:0] i_num_words = '0;
    logic             i_byte_valid = 1'b0;
    logic [7:0]       i_byte = '0;
    logic             o_byte_ready;
    logic             o_imem_we;
    logic [31:0]      o_imem_addr;
    logic [31:0]      o_imem_wdata;
    logic             o_busy;
    logic             o_cpu_hold;
    logic             o_done;
    logic             o_error;

    imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .i_num_words  (i_num_words),
        .i_byte_valid (i_byte_valid),
        .i_byte       (i_byte),
        .o_byte_ready (o_byte_ready),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_wdata (o_imem_wdata),
        .o_busy       (o_busy),
        .o_cpu_hold   (o_cpu_hold),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] words[2];
    logic [7:0]  run_xor;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && o_imem_we) begin
            if (sb.size() == 0) begin
                chk("unexpected_we", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("we_addr", o_imem_addr, e.addr);
                chk("we_data", o_imem_wdata, e.data);
                chk("we_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Returns the cycle index at which the byte was accepted.
    task automatic send_byte(input logic [7:0] b, output int acc);
        int t = 0;
        acc = -1;
        @(negedge clk);
        while (!o_byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!o_byte_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        i_byte_valid = 1'b1;
        i_byte = b;
        acc = cyc;
        @(posedge clk);
        #1 i_byte_valid = 1'b0;
    endtask

    task automatic send_words(input int n, input int gap);
        int acc;
        exp_t e;
        run_xor = '0;
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                logic [31:0] wv;
                logic [7:0] b;
                wv = words[w];
                b = wv[31-8*k -: 8];
                run_xor = run_xor ^ b;
                repeat (gap) @(negedge clk);
                send_byte(b, acc);
                if (k == 3) begin
                    e.addr = 32'(w) * 32'd4;
                    e.data = wv;
                    e.cyc = acc + 1;
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic start_load(input int n);
        @(negedge clk);
        i_start = 1'b1;
        i_num_words = CNT_W'(n);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!o_done && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(o_done), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_we"}, 32'(o_imem_we), 32'd0);
        chk({tag, "_addr"}, o_imem_addr, 32'd0);
        chk({tag, "_wdata"}, o_imem_wdata, 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_hold"}, 32'(o_cpu_hold), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
        chk({tag, "_error"}, 32'(o_error), 32'd0);
        chk({tag, "_ready"}, 32'(o_byte_ready), 32'd0);
    endtask

    initial begin
        int acc;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        reset = 1'b0;

        // Normal load
        words[0] = 32'h20080005;
        words[1] = 32'h8C010004;
        start_load(2);
        chk("norm_busy", 32'(o_busy), 32'd1);
        chk("norm_hold", 32'(o_cpu_hold), 32'd1);
        send_words(2, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("norm_xor_model", 32'(run_xor), 32'hA4);
        send_byte(run_xor, acc);
`endif
        wait_done("norm_done");
        chk("norm_busy_end", 32'(o_busy), 32'd0);
        chk("norm_error", 32'(o_error), 32'd0);
        chk("norm_sb_empty", 32'(sb.size()), 32'd0);

        // Empty load
        start_load(0);
        chk("empty_done", 32'(o_done), 32'd1);
        chk("empty_busy", 32'(o_busy), 32'd0);
        chk("empty_error", 32'(o_error), 32'd0);
        repeat (3) @(negedge clk);
        chk("empty_busy_later", 32'(o_busy), 32'd0);

        // Overflow
        start_load(DEPTH + 1);
        chk("ovf_done", 32'(o_done), 32'd1);
        chk("ovf_error", 32'(o_error), 32'd1);
        chk("ovf_ready", 32'(o_byte_ready), 32'd0);
        chk("ovf_busy", 32'(o_busy), 32'd0);

        // Throttled stream; a start pulse mid-load must be ignored
        start_load(2);
        chk("thr_err_clr", 32'(o_error), 32'd0);
        chk("thr_done_clr", 32'(o_done), 32'd0);
        start_load(0);
        chk("thr_start_ign", 32'(o_busy), 32'd1);
        send_words(2, 3);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(run_xor, acc);
`endif
        wait_done("thr_done");
        chk("thr_error", 32'(o_error), 32'd0);
        chk("thr_sb_empty", 32'(sb.size()), 32'd0);
        chk("thr_hold_addr", o_imem_addr, 32'h4);
        chk("thr_hold_data", o_imem_wdata, 32'h8C010004);

        // Reset mid-word
        start_load(2);
        send_byte(8'h20, acc);
        send_byte(8'h08, acc);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        reset = 1'b0;
        words[0] = 32'h0000000C;
        start_load(1);
        send_words(1, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h0C, acc);
`endif
        wait_done("restart_done");
        chk("restart_error", 32'(o_error), 32'd0);
        chk("restart_sb_empty", 32'(sb.size()), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        words[0] = 32'h01020304;
        start_load(1);
        send_words(1, 0);
        send_byte(8'h04, acc);
        wait_done("ck_ok_done");
        chk("ck_ok_error", 32'(o_error), 32'd0);
        start_load(1);
        send_words(1, 1);
        send_byte(8'h05, acc);
        wait_done("ck_bad_done");
        chk("ck_bad_error", 32'(o_error), 32'd1);
        chk("ck_sb_empty", 32'(sb.size()), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
